// File: rtl/melody_game_core.sv
`default_nettype none
// ============================================================================
//  Module   : melody_game_core
//  Purpose  : Simon-style melody echo game. Plays the first `level` notes of a
//             stored melody, listens for the player to echo them back, grows
//             the echo length on success and ends with a full-length quiz
//             that counts misses.
//  Revision : 1.0 - initial release
// ============================================================================
module melody_game_core #(
  parameter int NOTE_W    = 4,
  parameter int SEQ_LEN   = 8,
  parameter int START_LEN = 3,
  parameter int TICK_DIV  = 5000000,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NOTE_W*SEQ_LEN-1:0]      seq_in,
  input  logic                           seq_load,
  input  logic [NOTE_W-1:0]              answer,
  input  logic                           answer_valid,
  output logic [NOTE_W-1:0]              piezo_out,
  output logic [NOTE_W-1:0]              led_out,
  output logic [2:0]                     state_out,
  output logic                           miss_out,
  output logic                           hit_out,
  output logic                           level_up_out,
  output logic [$clog2(SEQ_LEN+1)-1:0]   level_out,
  output logic [7:0]                     miss_count_out
);

  localparam int c_idx_w     = $clog2(SEQ_LEN);
  localparam int c_lvl_w     = $clog2(SEQ_LEN + 1);
  localparam int c_tick_w    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_max_ticks = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int c_ph_w      = (c_max_ticks > 1) ? $clog2(c_max_ticks) : 1;

  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
  localparam logic [c_ph_w-1:0]   c_on_last   = c_ph_w'(ON_TICKS - 1);
  localparam logic [c_ph_w-1:0]   c_off_last  = c_ph_w'(OFF_TICKS - 1);
  localparam logic [c_lvl_w-1:0]  c_start_lvl = c_lvl_w'(START_LEN);
  localparam logic [c_lvl_w-1:0]  c_full_lvl  = c_lvl_w'(SEQ_LEN);
  localparam logic [c_idx_w-1:0]  c_last_idx  = c_idx_w'(SEQ_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAY_ON  = 3'd1,
    S_PLAY_OFF = 3'd2,
    S_LISTEN   = 3'd3,
    S_QUIZ     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t                      r_state,      w_state_nxt;
  logic [NOTE_W*SEQ_LEN-1:0]   r_seq,        w_seq_nxt;
  logic [c_lvl_w-1:0]          r_level,      w_level_nxt;
  logic [c_idx_w-1:0]          r_play_idx,   w_play_idx_nxt;
  logic [c_idx_w-1:0]          r_ans_idx,    w_ans_idx_nxt;
  logic [c_tick_w-1:0]         r_tick_cnt,   w_tick_cnt_nxt;
  logic [c_ph_w-1:0]           r_phase_cnt,  w_phase_cnt_nxt;
  logic [7:0]                  r_miss_count, w_miss_count_nxt;
  logic [NOTE_W-1:0]           r_piezo,      w_piezo_nxt;
  logic [NOTE_W-1:0]           r_led,        w_led_nxt;
  logic                        r_hit,        w_hit_nxt;
  logic                        r_miss,       w_miss_nxt;
  logic                        r_level_up,   w_level_up_nxt;

  logic                        w_tick;
  logic                        w_ans_match;
  logic                        w_phase_clr;
  logic [c_ph_w-1:0]           w_phase_step;
  logic [NOTE_W-1:0]           w_notes [SEQ_LEN];

  // Note view of the sequence as it will be after this edge, so a fresh load
  // drives its first note out on the very edge that accepts it.
  assign w_seq_nxt = seq_load ? seq_in : r_seq;

  for (genvar k = 0; k < SEQ_LEN; k++) begin : g_notes
    assign w_notes[k] = w_seq_nxt[NOTE_W*k +: NOTE_W];
  end

  assign w_tick      = (r_tick_cnt == c_tick_last);
  assign w_ans_match = (answer == w_notes[r_ans_idx]);

  // Next-state, index, counter and registered-output computation.
  always_comb begin
    w_state_nxt      = r_state;
    w_level_nxt      = r_level;
    w_play_idx_nxt   = r_play_idx;
    w_ans_idx_nxt    = r_ans_idx;
    w_miss_count_nxt = r_miss_count;
    w_hit_nxt        = 1'b0;
    w_miss_nxt       = 1'b0;
    w_level_up_nxt   = 1'b0;
    w_phase_step     = r_phase_cnt;
    w_piezo_nxt      = '0;
    w_led_nxt        = '0;

    if (seq_load) begin
      // A load restarts the game from any state and swallows any answer.
      w_level_nxt      = c_start_lvl;
      w_play_idx_nxt   = '0;
      w_ans_idx_nxt    = '0;
      w_miss_count_nxt = '0;
      w_state_nxt      = (seq_in == '0) ? S_IDLE : S_PLAY_ON;
    end else begin
      case (r_state)
        S_PLAY_ON: begin
          if (w_tick) begin
            if (r_phase_cnt == c_on_last) w_state_nxt  = S_PLAY_OFF;
            else                          w_phase_step = r_phase_cnt + c_ph_w'(1);
          end
        end
        S_PLAY_OFF: begin
          if (w_tick) begin
            if (r_phase_cnt == c_off_last) begin
              if (c_lvl_w'(r_play_idx) == r_level - c_lvl_w'(1)) begin
                w_state_nxt   = S_LISTEN;
                w_ans_idx_nxt = '0;
              end else begin
                w_play_idx_nxt = r_play_idx + c_idx_w'(1);
                w_state_nxt    = S_PLAY_ON;
              end
            end else begin
              w_phase_step = r_phase_cnt + c_ph_w'(1);
            end
          end
        end
        S_LISTEN: begin
          if (answer_valid) begin
            if (w_ans_match) begin
              w_hit_nxt = 1'b1;
              if (c_lvl_w'(r_ans_idx) == r_level - c_lvl_w'(1)) begin
                w_level_up_nxt = 1'b1;
                if (r_level < c_full_lvl) begin
                  w_level_nxt    = r_level + c_lvl_w'(1);
                  w_play_idx_nxt = '0;
                  w_state_nxt    = S_PLAY_ON;
                end else begin
                  w_ans_idx_nxt = '0;
                  w_state_nxt   = S_QUIZ;
                end
              end else begin
                w_ans_idx_nxt = r_ans_idx + c_idx_w'(1);
              end
            end else begin
              w_miss_nxt     = 1'b1;
              w_play_idx_nxt = '0;
              w_state_nxt    = S_PLAY_ON;
            end
          end
        end
        S_QUIZ: begin
          if (answer_valid) begin
            if (w_ans_match) begin
              w_hit_nxt = 1'b1;
            end else begin
              w_miss_nxt = 1'b1;
              if (r_miss_count != 8'hFF) w_miss_count_nxt = r_miss_count + 8'd1;
            end
            if (r_ans_idx == c_last_idx) w_state_nxt   = S_DONE;
            else                         w_ans_idx_nxt = r_ans_idx + c_idx_w'(1);
          end
        end
        default: ;
      endcase
    end

    // Every entry into a timed state (including re-entry on reload) restarts
    // the tick divider so each phase lasts whole ticks.
    w_phase_clr     = seq_load || (w_state_nxt != r_state);
    w_phase_cnt_nxt = w_phase_clr ? '0 : w_phase_step;
    w_tick_cnt_nxt  = (w_phase_clr || w_tick) ? '0 : r_tick_cnt + c_tick_w'(1);

    // Outputs follow the state being entered so they line up with state_out.
    case (w_state_nxt)
      S_PLAY_ON: begin
        w_piezo_nxt = w_notes[w_play_idx_nxt];
        w_led_nxt   = w_notes[w_play_idx_nxt];
      end
      S_LISTEN: begin
        // The last correctly echoed note stays lit until the next answer.
        if (r_state == S_LISTEN) w_led_nxt = w_hit_nxt ? answer : r_led;
      end
      S_QUIZ: begin
        w_led_nxt = w_notes[w_ans_idx_nxt];
      end
      default: ;
    endcase
  end

  // State register: all game state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_seq        <= '0;
      r_level      <= c_start_lvl;
      r_play_idx   <= '0;
      r_ans_idx    <= '0;
      r_tick_cnt   <= '0;
      r_phase_cnt  <= '0;
      r_miss_count <= '0;
      r_piezo      <= '0;
      r_led        <= '0;
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;
      r_level_up   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_seq        <= w_seq_nxt;
      r_level      <= w_level_nxt;
      r_play_idx   <= w_play_idx_nxt;
      r_ans_idx    <= w_ans_idx_nxt;
      r_tick_cnt   <= w_tick_cnt_nxt;
      r_phase_cnt  <= w_phase_cnt_nxt;
      r_miss_count <= w_miss_count_nxt;
      r_piezo      <= w_piezo_nxt;
      r_led        <= w_led_nxt;
      r_hit        <= w_hit_nxt;
      r_miss       <= w_miss_nxt;
      r_level_up   <= w_level_up_nxt;
    end
  end

  assign state_out      = r_state;
  assign piezo_out      = r_piezo;
  assign led_out        = r_led;
  assign hit_out        = r_hit;
  assign miss_out       = r_miss;
  assign level_up_out   = r_level_up;
  assign level_out      = r_level;
  assign miss_count_out = r_miss_count;

endmodule
`default_nettype wire
